// File: rtl/pcs_am_pkg.sv
// Shared alignment-marker definitions for the 100GbE PCS transmit and receive paths:
// sync headers, inserter state encoding, the per-lane M0..M2 table and the AM builder.
package pcs_am_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [0:0] ST_INSERT = 1'b0;
    localparam logic [0:0] ST_PASS   = 1'b1;

    localparam int AM_LANES_MAX = 20;

    // {M0, M1, M2} per PCS lane
    localparam logic [23:0] AM_TABLE [AM_LANES_MAX] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    // Bytes M0 M1 M2 BIP3 then their complements, above a control sync header
    function automatic logic [65:0] am_block(input logic [4:0] lane, input logic [7:0] bip);
        logic [23:0] m;
        m = AM_TABLE[lane];
        return {~bip, ~m[7:0], ~m[15:8], ~m[23:16], bip, m[7:0], m[15:8], m[23:16], SYNC_CTRL};
    endfunction

endpackage

// File: rtl/am_bip_fold.sv
// Folds a 66-bit block into the 8-bit BIP contribution; the sync header
// bits land on BIP bits 3 and 4.
module am_bip_fold (
    input  logic [65:0] block_i,
    output logic [7:0]  fold_o
);

    always_comb begin
        fold_o = '0;
        for (int k = 0; k < 8; k++) begin
            fold_o = fold_o ^ block_i[2 + 8*k +: 8];
        end
        fold_o[3] = fold_o[3] ^ block_i[0];
        fold_o[4] = fold_o[4] ^ block_i[1];
    end

endmodule

// File: rtl/am_insertion.sv
// Transmit alignment-marker inserter: round-robin lane assignment, AM group every
// N_BLOCKS blocks per lane, per-lane BIP accumulators updated from the output register.
module am_insertion
    import pcs_am_pkg::*;
#(
    parameter int N_LANES   = 20,
    parameter int N_BLOCKS  = 16383,
    parameter int NB_LANE   = $clog2(N_LANES),
    parameter int NB_PERIOD = $clog2(N_BLOCKS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [65:0]        i_data,
    output logic               o_ready,
    output logic               o_valid,
    output logic [65:0]        o_data,
    output logic               o_am,
    output logic [NB_LANE-1:0] o_lane
);

    localparam int PW = (NB_PERIOD < 1) ? 1 : NB_PERIOD;

    logic [0:0]         state_q, state_d;
    logic [NB_LANE-1:0] lane_q, lane_d, lane_inc;
    logic [PW-1:0]      period_q, period_d;
    logic               o_valid_q, o_valid_d;
    logic               o_am_q, o_am_d;
    logic [65:0]        o_data_q, o_data_d;
    logic [NB_LANE-1:0] o_lane_q, o_lane_d;
    logic [7:0]         bip_q [N_LANES];
    logic [7:0]         fold;
    logic [7:0]         bip_cur;
    logic               lane_last, period_last, accept;

    am_bip_fold u_fold (
        .block_i (o_data_q),
        .fold_o  (fold)
    );

    assign lane_last   = (lane_q == NB_LANE'(N_LANES - 1));
    assign period_last = (period_q == PW'(N_BLOCKS - 1));
    assign lane_inc    = lane_last ? '0 : lane_q + 1'b1;
    assign o_ready     = (state_q == ST_PASS) && i_enable && !i_reset;
    assign accept      = i_valid && o_ready;

    // The block in the output register has not been folded into bip_q yet
    always_comb begin
        bip_cur = bip_q[lane_q];
        if (o_valid_q && (o_lane_q == lane_q)) begin
            bip_cur = o_am_q ? fold : (bip_q[lane_q] ^ fold);
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        period_d  = period_q;
        o_valid_d = 1'b0;
        o_am_d    = 1'b0;
        o_data_d  = o_data_q;
        o_lane_d  = o_lane_q;
        if (state_q == ST_INSERT) begin
            o_valid_d = 1'b1;
            o_am_d    = 1'b1;
            o_data_d  = am_block(5'(lane_q), bip_cur);
            o_lane_d  = lane_q;
            lane_d    = lane_inc;
            if (lane_last) begin
                period_d = '0;
                state_d  = ST_PASS;
            end
        end else if (accept) begin
            o_valid_d = 1'b1;
            o_data_d  = i_data;
            o_lane_d  = lane_q;
            lane_d    = lane_inc;
            if (lane_last) begin
                period_d = period_q + 1'b1;
                if (period_last) begin
                    state_d = ST_INSERT;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_INSERT;
            lane_q    <= '0;
            period_q  <= '0;
            o_valid_q <= 1'b0;
            o_am_q    <= 1'b0;
            o_data_q  <= '0;
            o_lane_q  <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                bip_q[i] <= '0;
            end
        end else if (i_enable) begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            period_q  <= period_d;
            o_valid_q <= o_valid_d;
            o_am_q    <= o_am_d;
            o_data_q  <= o_data_d;
            o_lane_q  <= o_lane_d;
            // An AM restarts its lane's window; data blocks extend it
            if (o_valid_q) begin
                bip_q[o_lane_q] <= o_am_q ? fold : (bip_q[o_lane_q] ^ fold);
            end
        end
    end

    assign o_valid = o_valid_q && i_enable;
    assign o_am    = o_am_q && i_enable;
    assign o_data  = o_data_q;
    assign o_lane  = o_lane_q;

endmodule

// File: tb/tb_am_insertion.sv
// Directed bench for am_insertion with 4 lanes and 3 blocks per lane per period:
// a vector table for the first two AM groups, then gap, enable and reset sequences.
module tb_am_insertion;
    import pcs_am_pkg::*;

    localparam int NL  = 4;
    localparam int NBK = 3;

    logic        clk = 1'b0;
    logic        rst, en, vld;
    logic [65:0] din;
    logic        rdy, ov, oam;
    logic [65:0] odata;
    logic [1:0]  olane;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    am_insertion #(.N_LANES(NL), .N_BLOCKS(NBK)) dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_enable (en),
        .i_valid  (vld),
        .i_data   (din),
        .o_ready  (rdy),
        .o_valid  (ov),
        .o_data   (odata),
        .o_am     (oam),
        .o_lane   (olane)
    );

    typedef struct {
        logic        v;
        logic [65:0] d;
        logic        x_rdy;
        logic        x_v;
        logic        x_am;
        logic [1:0]  x_lane;
        logic [65:0] x_data;
    } vec_t;

    vec_t tbl [22];

    // Data block n: payload byte 0 = n, data sync header
    function automatic logic [65:0] blk(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {56'h0, b, SYNC_DATA};
    endfunction

    function automatic logic [65:0] am(input int lane, input logic [7:0] bip);
        logic [23:0] m;
        case (lane)
            0:       m = 24'hC16821;
            1:       m = 24'h9D718E;
            2:       m = 24'h594BE8;
            default: m = 24'h4D957B;
        endcase
        return {~bip, ~m[7:0], ~m[15:8], ~m[23:16], bip, m[7:0], m[15:8], m[23:16], 2'b01};
    endfunction

    task automatic check_v(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset release
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        vld = 1'b0;
        din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_out, data_cnt, groups, next_blk, lanes_seen;
        bit acc, done;
        int am_lane_q[$];
        logic [7:0] am_bip_q[$];

        // ---------------- reset values ----------------
        rst = 1'b1; en = 1'b1; vld = 1'b1; din = blk(7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_i("rst_valid", int'(ov), 0);
        check_i("rst_am", int'(oam), 0);
        check_i("rst_ready", int'(rdy), 0);
        check_i("rst_lane", int'(olane), 0);
        check_v("rst_data", odata, 66'h0);
        $display("reset: valid=%0b am=%0b ready=%0b lane=%0d data=%h", ov, oam, rdy, olane, odata);

        // ---------------- vector table: two AM groups with constant i_valid ----------------
        for (int c = 0; c < 22; c++) begin
            int pres;
            pres = (c <= 4) ? 1 : (c <= 15) ? c - 3 : (c <= 20) ? 13 : 14;
            tbl[c].v = 1'b1;
            tbl[c].d = blk(pres);
            if (c == 0) begin
                tbl[c].x_rdy = 0; tbl[c].x_v = 0; tbl[c].x_am = 0; tbl[c].x_lane = 0; tbl[c].x_data = '0;
            end else if (c <= 4) begin
                tbl[c].x_rdy = (c == 4); tbl[c].x_v = 1; tbl[c].x_am = 1;
                tbl[c].x_lane = 2'(c - 1); tbl[c].x_data = am(c - 1, 8'h00);
            end else if (c <= 16) begin
                tbl[c].x_rdy = (c <= 15); tbl[c].x_v = 1; tbl[c].x_am = 0;
                tbl[c].x_lane = 2'((c - 5) % 4); tbl[c].x_data = blk(c - 4);
            end else if (c <= 20) begin
                tbl[c].x_rdy = (c == 20); tbl[c].x_v = 1; tbl[c].x_am = 1;
                tbl[c].x_lane = 2'(c - 17); tbl[c].x_data = am(c - 17, 8'h15 + 8'(c - 17));
            end else begin
                tbl[c].x_rdy = 1; tbl[c].x_v = 1; tbl[c].x_am = 0; tbl[c].x_lane = 0; tbl[c].x_data = blk(13);
            end
        end

        do_reset();
        for (int c = 0; c < 22; c++) begin
            vld = tbl[c].v;
            din = tbl[c].d;
            @(negedge clk);
            check_i($sformatf("t%0d_ready", c), int'(rdy), int'(tbl[c].x_rdy));
            check_i($sformatf("t%0d_valid", c), int'(ov), int'(tbl[c].x_v));
            if (tbl[c].x_v) begin
                check_i($sformatf("t%0d_am", c), int'(oam), int'(tbl[c].x_am));
                check_i($sformatf("t%0d_lane", c), int'(olane), int'(tbl[c].x_lane));
                check_v($sformatf("t%0d_data", c), odata, tbl[c].x_data);
            end
            $display("row %0d: ready=%0b valid=%0b am=%0b lane=%0d data=%h", c, rdy, ov, oam, olane, odata);
            next_cycle();
        end

        // ---------------- first lane-0 AM as literal bytes ----------------
        do_reset();
        vld = 1'b1; din = blk(0);
        next_cycle();
        @(negedge clk);
        check_v("first_am_bytes", odata, {64'hFFDE973E002168C1, 2'b01});
        $display("first AM: lane=%0d data=%h", olane, odata);
        next_cycle();

        // ---------------- upstream gaps: i_valid 1010... ----------------
        do_reset();
        exp_out = 1; data_cnt = 0; groups = 0; next_blk = 1; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            vld = (cyc % 2 == 0);
            din = blk(next_blk);
            @(negedge clk);
            acc = vld && rdy;
            if (ov && !oam) begin
                check_v("gap_order", odata, blk(exp_out));
                check_i("gap_lane", int'(olane), (exp_out - 1) % 4);
                $display("gap: data block %0d on lane %0d", exp_out, olane);
                exp_out++;
                data_cnt++;
            end else if (ov && oam && data_cnt > 0) begin
                check_i("gap_spacing", data_cnt, 12);
                groups++;
                data_cnt = 0;
                if (groups == 2) done = 1;
            end
            next_cycle();
            if (acc) next_blk++;
        end
        check_i("gap_groups", groups, 2);

        // ---------------- i_enable low for 5 cycles mid-AM-group ----------------
        do_reset();
        vld = 1'b1; din = blk(0); done = 0;
        am_lane_q.delete(); am_bip_q.delete();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            en = !(cyc >= 2 && cyc < 7);
            @(negedge clk);
            if (!en) begin
                check_i("en_gap_valid", int'(ov), 0);
                check_i("en_gap_ready", int'(rdy), 0);
            end else if (ov && oam) begin
                am_lane_q.push_back(int'(olane));
                am_bip_q.push_back(odata[33:26]);
                $display("enable: AM lane %0d bip %h", olane, odata[33:26]);
            end else if (ov) begin
                done = 1;
            end
            next_cycle();
        end
        en = 1'b1;
        lanes_seen = am_lane_q.size();
        check_i("en_am_count", lanes_seen, 4);
        for (int i = 0; i < lanes_seen && i < 4; i++) begin
            check_i($sformatf("en_am%0d_lane", i), am_lane_q[i], i);
            check_i($sformatf("en_am%0d_bip", i), int'(am_bip_q[i]), 0);
        end

        // ---------------- reset during PASS period 1 ----------------
        do_reset();
        vld = 1'b1; din = blk(0);
        repeat (10) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_i("rr_c0_valid", int'(ov), 0);
        next_cycle();
        @(negedge clk);
        check_i("rr_am_valid", int'(ov & oam), 1);
        check_i("rr_am_lane", int'(olane), 0);
        check_v("rr_am_data", odata, am(0, 8'h00));
        $display("after reset: lane=%0d data=%h", olane, odata);
        next_cycle();
        data_cnt = 0; done = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (ov && !oam) begin
                data_cnt++;
            end else if (ov && oam && data_cnt > 0) begin
                check_i("rr_am2_lane", int'(olane), 0);
                check_v("rr_am2_bip", odata, {64'hE7DE973E182168C1, 2'b01});
                $display("after reset: second lane-0 AM %h after %0d blocks", odata, data_cnt);
                done = 1;
            end
            next_cycle();
        end
        check_i("rr_block_count", data_cnt, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/am_insertion.md
# am_insertion

Transmit-side alignment-marker inserter for the 100GbE PCS. It sits after the 64b/66b encoder and scrambler and before block distribution.
- Accepts one 66-bit block per enabled cycle and distributes blocks round-robin over `N_LANES` PCS lanes.
- After every `N_BLOCKS` data blocks per lane, it stalls upstream and emits one alignment marker per lane, carrying that lane's BIP.
- It produces the AM period and BIP that the receive-side AM lock and deskew logic consumes.

## Interface
- `N_LANES`, 20: number of PCS lanes; also the number of AMs per group.
- `N_BLOCKS`, 16383: data blocks per lane between consecutive AMs.
- `NB_LANE`, `$clog2(N_LANES)`: lane index width.
- `NB_PERIOD`, `$clog2(N_BLOCKS)`: period counter width.

Ports:
- `i_clock`, in, 1: clock.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_enable`, in, 1: global enable. When low, all registers hold.
- `i_valid`, in, 1: `i_data` is valid.
- `i_data`, in, 66: block; `[1:0]` is the sync header, bit n is transmitted n-th.
- `o_ready`, out, 1: block is accepted when `i_valid && o_ready`.
- `o_valid`, out, 1: `o_data` is valid.
- `o_data`, out, 66: output block (data or AM).
- `o_am`, out, 1: `o_data` is an alignment marker.
- `o_lane`, out, `NB_LANE`: lane that `o_data` belongs to.

## Operation
- **States:**
  - INSERT: emitting AMs; `o_ready` = 0.
  - PASS: forwarding data.
  - Reset state is INSERT with lane = 0 and period = 0, so an AM group goes out first after reset.
- **`o_ready`** = (state == PASS) & `i_enable`.
- **INSERT, each enabled cycle:**
  - Emit the AM for the current lane: `o_valid` = 1, `o_am` = 1.
  - Increment lane.
  - When lane = `N_LANES`-1 → lane wraps to 0, period := 0, state → PASS.
- **PASS, accepted block:**
  - Forward the block unchanged with `o_lane` = lane and increment lane.
  - When lane wraps, increment period.
  - When lane = `N_LANES`-1 and period = `N_BLOCKS`-1 → state → INSERT.
- **PASS, no accepted block:** `o_valid` = 0 and the counters hold.
- **AM format for lane L:**
  - `[1:0]` = 2'b01, i.e. bit0 = 1 (control sync).
  - `[9:2]` = M0, `[17:10]` = M1, `[25:18]` = M2, `[33:26]` = BIP3.
  - `[41:34]` = ~M0, `[49:42]` = ~M1, `[57:50]` = ~M2, `[65:58]` = ~BIP3.
  - M0–M2 come from the per-lane table (lane 0: C1, 68, 21; lane 1: 9D, 71, 8E; …).
- **BIP fold of a block b:**
  - f[i] = XOR over k = 0..7 of b[2+i+8k].
  - Additionally f[3] ^= b[0] and f[4] ^= b[1].
  - The fold of any AM is 0x08.
- **BIP accumulation:**
  - There are `N_LANES` 8-bit accumulators, reset to 0.
  - A data block emitted on lane L sets bip[L] ^= f(block).
  - An AM emitted on lane L uses BIP3 = bip[L], then sets bip[L] := f(AM).
  - The window therefore includes the previous AM and excludes the current one.
- **Enable low:** state, counters, accumulators and outputs are frozen, except that `o_valid` and `o_am` are forced to 0.
- **Reset mid-group or mid-period:** abort immediately and restart with a fresh AM group; all BIP accumulators are cleared.
- **Invariant:** every lane receives exactly one AM per `N_BLOCKS` data blocks. No data block is dropped or duplicated.

## Timing
- `o_data`, `o_valid`, `o_am` and `o_lane` are registered: 1-cycle latency from acceptance or AM generation.
- Reset values:
  - `o_valid`, `o_am`, `o_lane` = 0.
  - `o_data` = 0.
  - `o_ready` = 0 during reset and in INSERT.
- The first AM appears at `o_valid` on the first enabled cycle after reset release + 1.
- An AM group occupies exactly `N_LANES` enabled cycles with `o_ready` = 0.
- The last data block of a period is accepted at cycle t; `o_ready` = 0 from t+1.
- The last AM is generated at cycle t; `o_ready` = 1 at t+1 (if enabled).
- `i_valid` asserted while `o_ready` = 0 is not consumed; upstream holds the block.

## Structure
- Shared package `pcs_am_pkg`:
  - AM M0–M2 table, 20 × 24 bits.
  - Sync header constants (data 2'b10, control 2'b01).
  - Localparams for the state encoding.
- Sub-module `am_bip_fold`: combinational 66-bit → 8-bit fold.
  - Shared with the receive-side BIP checker.
  - Instantiated once on the registered output path.
- The top level contains the FSM, lane and period counters, the accumulator array and the output registers.

## Test plan
All scenarios use `N_LANES` = 4 and `N_BLOCKS` = 3 unless stated.
- **Reset then constant `i_valid`:**
  - Outputs 4 AMs (`o_lane` 0..3), then 12 data blocks, then 4 AMs.
  - Pattern repeats.
  - `o_ready` is low for exactly 4 cycles per group.
- **Lane 0 content, all-zero-payload data blocks (sync 2'b10):**
  - First AM = C1,68,21,00,3E,97,DE,FF.
  - Second lane-0 AM has BIP3 = 18 and BIP7 = E7.
- **Upstream gaps:** `i_valid` toggling 1010… → the data order is preserved and AM spacing still counts 3 accepted blocks per lane.
- **`i_enable` pulsed low for 5 cycles mid-AM-group** → no AM is lost or repeated; `o_valid` = 0 during the gap.
- **`i_reset` asserted during PASS period 1:**
  - Next output is AM lane 0 with BIP3 = 00.
  - The count restarts from zero.
- **Default parameters:** 20 AMs are emitted, then exactly 327660 data blocks are accepted before the next AM group.
